// File: rtl/pipe_chk_pkg.sv
// Shared types and helpers for the pipeline response checker: state enum,
// default sizing constants and a saturating increment.
package pipe_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } pipe_chk_state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 8;

    // Counters of any width up to SAT_W are widened to call sat_inc.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v);
        return (v == max_v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_resp_checker_if.sv
// Bundle between a stimulus bench (master) and the response checker (slave).
// First-error capture signals exist only when PIPE_CHECK_FIRST_ERR_EN is defined.
interface pipe_resp_checker_if
    import pipe_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    // start/stop are sampled levels, not a valid/ready handshake: the checker
    // acts on whatever level is present at each rising edge.
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] b_dut;
    logic [WIDTH-1:0] c_dut;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] sample_cnt;
    pipe_chk_state_t  dbg_state;
`ifdef PIPE_CHECK_FIRST_ERR_EN
    logic [CNT_W-1:0]   first_err_idx;
    logic [2*WIDTH-1:0] first_err_got;
    logic [2*WIDTH-1:0] first_err_exp;
    logic               first_err_vld;

    modport master (
        output start, stop, din, b_dut, c_dut,
        input  busy, done, pass, err_cnt, sample_cnt, dbg_state,
        input  first_err_idx, first_err_got, first_err_exp, first_err_vld
    );
    modport slave (
        input  start, stop, din, b_dut, c_dut,
        output busy, done, pass, err_cnt, sample_cnt, dbg_state,
        output first_err_idx, first_err_got, first_err_exp, first_err_vld
    );
`else
    modport master (
        output start, stop, din, b_dut, c_dut,
        input  busy, done, pass, err_cnt, sample_cnt, dbg_state
    );
    modport slave (
        input  start, stop, din, b_dut, c_dut,
        output busy, done, pass, err_cnt, sample_cnt, dbg_state
    );
`endif
endinterface

// File: rtl/pipe_chk_golden.sv
// Golden DEPTH-stage non-blocking shift register; stage 0 tracks din one edge late.
module pipe_chk_golden #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            din_i,
    output logic [DEPTH-1:0][WIDTH-1:0] stage_o
);
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/pipe_resp_checker.sv
// Response checker for two-stage register pipelines: FSM, saturating counters
// and verdict. Optional first-mismatch capture under PIPE_CHECK_FIRST_ERR_EN.
module pipe_resp_checker
    import pipe_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic               clk,
    input logic               reset,
    pipe_resp_checker_if.slave chk
);
    localparam int WU_W = $clog2(DEPTH + 1);
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    pipe_chk_state_t             state_q, state_d;
    logic [WU_W-1:0]             wu_cnt_q, wu_cnt_d;
    logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]            smp_cnt_q, smp_cnt_d;
    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [WIDTH-1:0]            exp_b, exp_c;
    logic                        mismatch, run_start, count_en;
    logic                        busy, done, pass;

    pipe_chk_golden #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_golden (
        .clk     (clk),
        .reset   (reset),
        .din_i   (chk.din),
        .stage_o (stage)
    );

    assign exp_b     = stage[0];
    assign exp_c     = stage[1];
    assign mismatch  = (chk.b_dut != exp_b) || (chk.c_dut != exp_c);
    assign run_start = ((state_q == IDLE) || (state_q == DONE)) && chk.start;
    assign count_en  = (state_q == CHECK) && !chk.stop;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // stop outranks the warm-up exit so a run can be aborted on any edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (chk.start) state_d = WARMUP;
            WARMUP: begin
                if (chk.stop)                             state_d = DONE;
                else if (wu_cnt_q == WU_W'(DEPTH - 1))    state_d = CHECK;
            end
            CHECK:   if (chk.stop) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == WARMUP) || (state_q == CHECK);
        done = (state_q == DONE);
        pass = done && (err_cnt_q == '0) && (smp_cnt_q != '0);
    end

    always_comb begin
        wu_cnt_d  = wu_cnt_q;
        err_cnt_d = err_cnt_q;
        smp_cnt_d = smp_cnt_q;
        if (run_start) begin
            wu_cnt_d  = '0;
            err_cnt_d = '0;
            smp_cnt_d = '0;
        end else if (state_q == WARMUP) begin
            wu_cnt_d = wu_cnt_q + 1'b1;
        end else if (count_en) begin
            smp_cnt_d = CNT_W'(sat_inc(SAT_W'(smp_cnt_q), CNT_MAX));
            if (mismatch) err_cnt_d = CNT_W'(sat_inc(SAT_W'(err_cnt_q), CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wu_cnt_q  <= '0;
            err_cnt_q <= '0;
            smp_cnt_q <= '0;
        end else begin
            wu_cnt_q  <= wu_cnt_d;
            err_cnt_q <= err_cnt_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end

    assign chk.busy       = busy;
    assign chk.done       = done;
    assign chk.pass       = pass;
    assign chk.err_cnt    = err_cnt_q;
    assign chk.sample_cnt = smp_cnt_q;
    assign chk.dbg_state  = state_q;

`ifdef PIPE_CHECK_FIRST_ERR_EN
    logic               fe_vld_q, fe_vld_d;
    logic [CNT_W-1:0]   fe_idx_q, fe_idx_d;
    logic [2*WIDTH-1:0] fe_got_q, fe_got_d;
    logic [2*WIDTH-1:0] fe_exp_q, fe_exp_d;

    always_comb begin
        fe_vld_d = fe_vld_q;
        fe_idx_d = fe_idx_q;
        fe_got_d = fe_got_q;
        fe_exp_d = fe_exp_q;
        if (run_start) begin
            fe_vld_d = 1'b0;
            fe_idx_d = '0;
            fe_got_d = '0;
            fe_exp_d = '0;
        end else if (count_en && mismatch && !fe_vld_q) begin
            fe_vld_d = 1'b1;
            fe_idx_d = smp_cnt_q;
            fe_got_d = {chk.b_dut, chk.c_dut};
            fe_exp_d = {exp_b, exp_c};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fe_vld_q <= 1'b0;
            fe_idx_q <= '0;
            fe_got_q <= '0;
            fe_exp_q <= '0;
        end else begin
            fe_vld_q <= fe_vld_d;
            fe_idx_q <= fe_idx_d;
            fe_got_q <= fe_got_d;
            fe_exp_q <= fe_exp_d;
        end
    end

    assign chk.first_err_vld = fe_vld_q;
    assign chk.first_err_idx = fe_idx_q;
    assign chk.first_err_got = fe_got_q;
    assign chk.first_err_exp = fe_exp_q;
`endif

endmodule

// File: tb/tb_pipe_resp_checker.sv
// Bench for pipe_resp_checker: drives correct, blocking-style and corrupt DUT
// stand-ins; expected counts come from the din history of each run.
// First-error checks are compiled in when PIPE_CHECK_FIRST_ERR_EN is defined.
module tb_pipe_resp_checker;
    import pipe_chk_pkg::*;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   dut_mode = 0;    // 0: non-blocking, 1: blocking-style, 2: corrupt b

    logic [WIDTH-1:0]   hist[$];      // hist[k] = din sampled at edge k of the run
    logic [WIDTH-1:0]   stream_q[$];  // fixed words, consumed before random ones
    int                 exp_smp, exp_err, exp_fe_idx;
    logic               exp_fe_vld, exp_pass;
    logic [2*WIDTH-1:0] exp_fe_got, exp_fe_exp;

    pipe_resp_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pipe_resp_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .chk   (bus)
    );

    always #5 clk = ~clk;

    // DUT stand-ins sampling din on the same edge as the checker.
    logic [WIDTH-1:0] nb_b = '0, nb_c = '0, bl_b = '0;
    always @(posedge clk) begin
        nb_b <= bus.din;
        nb_c <= nb_b;
        bl_b <= bus.din;
    end
    assign bus.b_dut = (dut_mode == 0) ? nb_b : (dut_mode == 1) ? bl_b : (nb_b ^ WIDTH'(1));
    assign bus.c_dut = (dut_mode == 1) ? bl_b : nb_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int mode);
        dut_mode = mode;
        hist.delete();
        hist.push_back(bus.din);
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    // Feeds n words at e1..en, stop at e(n+1), then builds the expected result.
    task automatic feed_and_stop(input int n);
        logic [WIDTH-1:0] eb, ec, gb, gc;
        for (int k = 1; k <= n; k++) begin
            if (stream_q.size() != 0) bus.din = stream_q.pop_front();
            else                      bus.din = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            hist.push_back(bus.din);
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        exp_smp = 0; exp_err = 0; exp_fe_vld = 1'b0; exp_fe_idx = 0;
        exp_fe_got = '0; exp_fe_exp = '0;
        for (int k = DEPTH + 1; k <= n; k++) begin
            eb = hist[k-1];
            ec = hist[k-2];
            gb = (dut_mode == 2) ? (eb ^ WIDTH'(1)) : eb;
            gc = (dut_mode == 1) ? eb : ec;
            if ({gb, gc} != {eb, ec}) begin
                if (!exp_fe_vld) begin
                    exp_fe_vld = 1'b1;
                    exp_fe_idx = exp_smp;
                    exp_fe_got = {gb, gc};
                    exp_fe_exp = {eb, ec};
                end
                if (exp_err < CNT_MAX) exp_err++;
            end
            if (exp_smp < CNT_MAX) exp_smp++;
        end
        exp_pass = (exp_err == 0) && (exp_smp != 0);
    endtask

    task automatic test_reset();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b expected 0", bus.pass); end
        n_tests++; if (bus.err_cnt !== '0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", bus.err_cnt); end
        n_tests++; if (bus.sample_cnt !== '0) begin n_fail++; $display("FAIL reset_smp: got %0d expected 0", bus.sample_cnt); end
        n_tests++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", bus.dbg_state); end
    endtask

    task automatic test_match_stream();
        stream_q = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};
        start_run(0);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL match_warmup_busy: got %0b expected 1", bus.busy); end
        feed_and_stop(5);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL match_done: got %0b expected 1", bus.done); end
        n_tests++; if (bus.sample_cnt !== 8'd3) begin n_fail++; $display("FAIL match_smp: got %0d expected 3", bus.sample_cnt); end
        n_tests++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL match_err: got %0d expected 0", bus.err_cnt); end
        n_tests++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL match_pass: got %0b expected 1", bus.pass); end
    endtask

    task automatic test_blocking_stream();
        stream_q = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};
        start_run(1);
        feed_and_stop(5);
        n_tests++; if (bus.sample_cnt !== 8'd3) begin n_fail++; $display("FAIL blk_smp: got %0d expected 3", bus.sample_cnt); end
        n_tests++; if (bus.err_cnt !== 8'd3) begin n_fail++; $display("FAIL blk_err: got %0d expected 3", bus.err_cnt); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL blk_pass: got %0b expected 0", bus.pass); end
`ifdef PIPE_CHECK_FIRST_ERR_EN
        n_tests++; if (bus.first_err_vld !== 1'b1) begin n_fail++; $display("FAIL blk_fe_vld: got %0b expected 1", bus.first_err_vld); end
        n_tests++; if (bus.first_err_idx !== 8'd0) begin n_fail++; $display("FAIL blk_fe_idx: got %0d expected 0", bus.first_err_idx); end
        n_tests++; if (bus.first_err_got !== 8'h77) begin n_fail++; $display("FAIL blk_fe_got: got %h expected 77", bus.first_err_got); end
        n_tests++; if (bus.first_err_exp !== 8'h73) begin n_fail++; $display("FAIL blk_fe_exp: got %h expected 73", bus.first_err_exp); end
`endif
    endtask

    task automatic test_saturation();
        start_run(2);
        feed_and_stop(302);
        n_tests++; if (bus.err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_err: got %0d expected 255", bus.err_cnt); end
        n_tests++; if (bus.sample_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_smp: got %0d expected 255", bus.sample_cnt); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %0b expected 0", bus.pass); end
    endtask

    task automatic test_early_stop();
        start_run(0);
        feed_and_stop(0);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL early_done: got %0b expected 1", bus.done); end
        n_tests++; if (bus.sample_cnt !== 8'd0) begin n_fail++; $display("FAIL early_smp: got %0d expected 0", bus.sample_cnt); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL early_pass: got %0b expected 0", bus.pass); end
    endtask

    task automatic test_start_stop_together();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.dbg_state !== WARMUP) begin n_fail++; $display("FAIL both_idle_state: got %0d expected WARMUP", bus.dbg_state); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL both_idle_busy: got %0b expected 1", bus.busy); end
        tick();
        bus.stop = 1'b0;
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL both_warmup_done: got %0b expected 1", bus.done); end
    endtask

    task automatic test_reset_mid_check();
        start_run(2);
        for (int k = 1; k <= 4; k++) begin
            bus.din = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            tick();
        end
        n_tests++; if (bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL midrst_pre_err: got %0d expected 2", bus.err_cnt); end
        reset = 1'b1;
        tick();
        n_tests++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected IDLE", bus.dbg_state); end
        n_tests++; if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b expected 000", {bus.busy, bus.done, bus.pass}); end
        n_tests++; if ({bus.err_cnt, bus.sample_cnt} !== 16'h0) begin n_fail++; $display("FAIL midrst_cnts: got %h expected 0000", {bus.err_cnt, bus.sample_cnt}); end
`ifdef PIPE_CHECK_FIRST_ERR_EN
        n_tests++; if (bus.first_err_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_fe_vld: got %0b expected 0", bus.first_err_vld); end
`endif
        reset = 1'b0;
        start_run(0);
        feed_and_stop(6);
        n_tests++; if (bus.sample_cnt !== 8'd4) begin n_fail++; $display("FAIL midrst_new_smp: got %0d expected 4", bus.sample_cnt); end
        n_tests++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_new_err: got %0d expected 0", bus.err_cnt); end
        n_tests++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL midrst_new_pass: got %0b expected 1", bus.pass); end
    endtask

    task automatic test_rerun();
        start_run(2);
        feed_and_stop(5);
        start_run(0);
        n_tests++; if ({bus.err_cnt, bus.sample_cnt} !== 16'h0) begin n_fail++; $display("FAIL rerun_clear: got %h expected 0000", {bus.err_cnt, bus.sample_cnt}); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rerun_busy: got %0b expected 1", bus.busy); end
        feed_and_stop(7);
        n_tests++; if (bus.sample_cnt !== 8'd5) begin n_fail++; $display("FAIL rerun_smp: got %0d expected 5", bus.sample_cnt); end
        n_tests++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL rerun_pass: got %0b expected 1", bus.pass); end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 12; r++) begin
            start_run(int'($urandom_range(0, 2)));
            feed_and_stop(int'($urandom_range(0, 25)));
            n_tests++; if (bus.sample_cnt !== CNT_W'(exp_smp)) begin n_fail++; $display("FAIL rand_smp[%0d]: got %0d expected %0d", r, bus.sample_cnt, exp_smp); end
            n_tests++; if (bus.err_cnt !== CNT_W'(exp_err)) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d expected %0d", r, bus.err_cnt, exp_err); end
            n_tests++; if (bus.pass !== exp_pass) begin n_fail++; $display("FAIL rand_pass[%0d]: got %0b expected %0b", r, bus.pass, exp_pass); end
            n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rand_done[%0d]: got %0b expected 1", r, bus.done); end
`ifdef PIPE_CHECK_FIRST_ERR_EN
            n_tests++; if (bus.first_err_vld !== exp_fe_vld) begin n_fail++; $display("FAIL rand_fe_vld[%0d]: got %0b expected %0b", r, bus.first_err_vld, exp_fe_vld); end
            n_tests++; if (bus.first_err_idx !== CNT_W'(exp_fe_idx)) begin n_fail++; $display("FAIL rand_fe_idx[%0d]: got %0d expected %0d", r, bus.first_err_idx, exp_fe_idx); end
            n_tests++; if ({bus.first_err_got, bus.first_err_exp} !== {exp_fe_got, exp_fe_exp}) begin n_fail++; $display("FAIL rand_fe_data[%0d]: got %h/%h expected %h/%h", r, bus.first_err_got, bus.first_err_exp, exp_fe_got, exp_fe_exp); end
`endif
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.din   = '0;
        reset     = 1'b1;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        test_match_stream();
        test_blocking_stream();
        test_saturation();
        test_early_stop();
        test_start_stop_together();
        test_reset_mid_check();
        test_rerun();
        test_random_runs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
